// File: rtl/imem_responder.sv
// Instruction-memory responder: bootloads a program from a byte-serial valid/ready
// stream into word RAM, then serves fetch reads with one cycle of latency.
module imem_responder #(
  parameter int          DEPTH_WORDS   = 1024,
  parameter logic [31:0] NOP_INST      = 32'h0000_0013,
  parameter bit          LOAD_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] rd_ram_addr,
  output logic [31:0] rd_ram_data,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  output logic        load_ready,
  input  logic        load_done,
  input  logic        reload,
  output logic        serving,
  output logic [14:0] loaded_words
);

  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam logic [AW:0] PTR_END = (AW+1)'(DEPTH_WORDS);
  localparam logic [14:0] CNT_MAX = 15'(DEPTH_WORDS);

  typedef enum logic [0:0] {ST_LOAD = 1'b0, ST_SERVE = 1'b1} state_t;
  localparam state_t RESET_STATE = LOAD_ON_RESET ? ST_LOAD : ST_SERVE;

  state_t      r_state;
  state_t      w_state_next;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_asm;
  logic [AW:0] r_wr_ptr;
  logic [14:0] r_loaded_words;
  logic [31:0] r_rd_data;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_xfer;
  logic        w_full;
  logic        w_done_ld;
  logic        w_we;
  logic [1:0]  w_cnt_next;
  logic [23:0] w_asm_next;
  logic [31:0] w_wdata;
  logic [AW:0] w_ptr_inc;
  logic [13:0] w_idx;
  logic        w_in_range;
  logic        w_unused;

  assign load_ready   = (r_state == ST_LOAD);
  assign serving      = (r_state == ST_SERVE);
  assign loaded_words = r_loaded_words;
  assign rd_ram_data  = r_rd_data;

  assign w_idx      = rd_ram_addr[15:2];
  assign w_unused   = ^rd_ram_addr[1:0];
  // Full 14-bit compare so out-of-range addresses never alias onto low words.
  assign w_in_range = ({1'b0, w_idx} < CNT_MAX);

  // Byte assembly, commit decision and next state.
  always_comb begin
    w_xfer       = load_valid & (r_state == ST_LOAD);
    w_full       = w_xfer & (r_byte_cnt == 2'd3);
    w_done_ld    = load_done & (r_state == ST_LOAD);
    w_cnt_next   = w_xfer ? (r_byte_cnt + 2'd1) : r_byte_cnt;
    w_asm_next   = r_asm;
    if (w_xfer) begin
      case (r_byte_cnt)
        2'd0:    w_asm_next[7:0]   = load_byte;
        2'd1:    w_asm_next[15:8]  = load_byte;
        2'd2:    w_asm_next[23:16] = load_byte;
        default: w_asm_next        = r_asm;
      endcase
    end else begin
      w_asm_next = r_asm;
    end
    // Lanes are cleared after every commit, so a partial word is already zero-filled.
    w_we         = w_full | (w_done_ld & (w_cnt_next != 2'd0));
    w_wdata      = w_full ? {load_byte, r_asm} : {8'h00, w_asm_next};
    w_ptr_inc    = r_wr_ptr + (AW+1)'(1);
    w_state_next = r_state;
    case (r_state)
      ST_LOAD: begin
        if (w_done_ld || (w_we && (w_ptr_inc == PTR_END))) begin
          w_state_next = ST_SERVE;
        end else begin
          w_state_next = ST_LOAD;
        end
      end
      ST_SERVE: begin
        if (reload) begin
          w_state_next = ST_LOAD;
        end else begin
          w_state_next = ST_SERVE;
        end
      end
      default: w_state_next = RESET_STATE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= RESET_STATE;
      r_byte_cnt     <= 2'd0;
      r_asm          <= 24'h00_0000;
      r_wr_ptr       <= '0;
      r_loaded_words <= 15'd0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == ST_SERVE) && reload) begin
        r_byte_cnt     <= 2'd0;
        r_asm          <= 24'h00_0000;
        r_wr_ptr       <= '0;
        r_loaded_words <= 15'd0;
      end else if (w_we) begin
        r_byte_cnt <= 2'd0;
        r_asm      <= 24'h00_0000;
        r_wr_ptr   <= w_ptr_inc;
        if (r_loaded_words < CNT_MAX) begin
          r_loaded_words <= r_loaded_words + 15'd1;
        end
      end else if (w_done_ld) begin
        r_byte_cnt <= 2'd0;
        r_asm      <= 24'h00_0000;
      end else begin
        r_byte_cnt <= w_cnt_next;
        r_asm      <= w_asm_next;
      end
    end
  end

  // Program RAM is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_wr_ptr[AW-1:0]] <= w_wdata;
    end
  end

  // Reads use the pre-edge state, so nothing but NOP escapes while loading.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= NOP_INST;
    end else if ((r_state == ST_SERVE) && w_in_range) begin
      r_rd_data <= r_mem[w_idx[AW-1:0]];
    end else begin
      r_rd_data <= NOP_INST;
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench: two responders (1024 and 4 words) share one directed stimulus
// stream and are compared each cycle against a word/byte-list model plus literal checks.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [15:0] rd_ram_addr;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_done;
  logic        reload;
  logic [31:0] rd_data   [2];
  logic        ready_o   [2];
  logic        serving_o [2];
  logic [14:0] loaded_o  [2];

  int n_checks;
  int n_err;

  imem_responder u_big (
    .clk(clk), .reset(reset), .rd_ram_addr(rd_ram_addr), .rd_ram_data(rd_data[0]),
    .load_valid(load_valid), .load_byte(load_byte), .load_ready(ready_o[0]),
    .load_done(load_done), .reload(reload), .serving(serving_o[0]), .loaded_words(loaded_o[0])
  );

  imem_responder #(.DEPTH_WORDS(4)) u_small (
    .clk(clk), .reset(reset), .rd_ram_addr(rd_ram_addr), .rd_ram_data(rd_data[1]),
    .load_valid(load_valid), .load_byte(load_byte), .load_ready(ready_o[1]),
    .load_done(load_done), .reload(reload), .serving(serving_o[1]), .loaded_words(loaded_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: RAM image, list of buffered bytes, word count and mode.
  int          depth [2];
  logic [31:0] m_mem     [2][1024];
  bit          m_known   [2][1024];
  logic [7:0]  m_pend    [2][4];
  int          m_cnt     [2];
  int          m_wptr    [2];
  int          m_loaded  [2];
  bit          m_serving [2];
  logic [31:0] m_rd      [2];
  bit          m_rd_known[2];

  function automatic logic [31:0] pack_lanes(int k, int n);
    logic [31:0] w;
    w = 32'h0;
    for (int j = 0; j < n; j++) w[8*j +: 8] = m_pend[k][j];
    return w;
  endfunction

  task automatic commit(int k);
    m_mem[k][m_wptr[k]]   = pack_lanes(k, m_cnt[k]);
    m_known[k][m_wptr[k]] = 1'b1;
    m_wptr[k]++;
    if (m_loaded[k] < depth[k]) m_loaded[k]++;
    m_cnt[k] = 0;
    if (m_wptr[k] == depth[k]) m_serving[k] = 1'b1;
  endtask

  task automatic model_update();
    int idx;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_cnt[k] = 0; m_wptr[k] = 0; m_loaded[k] = 0; m_serving[k] = 1'b0;
        m_rd[k] = NOP; m_rd_known[k] = 1'b1;
      end else begin
        idx = int'(rd_ram_addr) / 4;
        if (m_serving[k] && idx < depth[k]) begin
          m_rd[k] = m_mem[k][idx]; m_rd_known[k] = m_known[k][idx];
        end else begin
          m_rd[k] = NOP; m_rd_known[k] = 1'b1;
        end
        if (!m_serving[k]) begin
          if (load_valid) begin
            m_pend[k][m_cnt[k]] = load_byte;
            m_cnt[k]++;
            if (m_cnt[k] == 4) commit(k);
          end
          if (load_done) begin
            if (m_cnt[k] != 0) commit(k);
            m_serving[k] = 1'b1;
          end
        end else if (reload) begin
          m_serving[k] = 1'b0; m_wptr[k] = 0; m_loaded[k] = 0; m_cnt[k] = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    depth[0] = 1024;
    depth[1] = 4;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 1024; i++) m_known[k][i] = 1'b0;
      m_cnt[k] = 0; m_wptr[k] = 0; m_loaded[k] = 0; m_serving[k] = 1'b0;
      m_rd[k] = NOP; m_rd_known[k] = 1'b1;
    end
    forever begin
      @(posedge clk or posedge reset);
      model_update();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("serving[%0d]", k), 32'(serving_o[k]), 32'(m_serving[k]));
        chk($sformatf("load_ready[%0d]", k), 32'(ready_o[k]), 32'(!m_serving[k]));
        chk($sformatf("loaded_words[%0d]", k), 32'(loaded_o[k]), 32'(m_loaded[k]));
        if (m_rd_known[k]) chk($sformatf("rd_ram_data[%0d]", k), rd_data[k], m_rd[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    load_valid = 1'b1; load_byte = b;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic send_done(input logic [7:0] b);
    load_valid = 1'b1; load_byte = b; load_done = 1'b1;
    tick();
    load_valid = 1'b0; load_done = 1'b0;
  endtask

  task automatic pulse_done();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    rd_ram_addr = a;
    tick();
  endtask

  logic [7:0] prog [8];

  initial begin
    n_checks = 0; n_err = 0;
    reset = 1'b0; rd_ram_addr = 16'h0000; load_valid = 1'b0; load_byte = 8'h00;
    load_done = 1'b0; reload = 1'b0;
    prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h50, 8'h00, 8'h00};
    #1 reset = 1'b1;
    #1;
    chk("reset_rd", rd_data[0], NOP);
    chk("reset_ready", 32'(ready_o[0]), 32'd1);
    chk("reset_serving", 32'(serving_o[0]), 32'd0);
    chk("reset_loaded", 32'(loaded_o[0]), 32'd0);
    tick(); tick();
    reset = 1'b0;

    // Reads in LOAD return NOP, then the 2-word program.
    rd(16'h0000);
    chk("load_rd_nop", rd_data[0], NOP);
    for (int i = 0; i < 8; i++) send(prog[i]);
    pulse_done();
    chk("t1_loaded", 32'(loaded_o[0]), 32'd2);
    chk("t1_serving", 32'(serving_o[0]), 32'd1);
    rd(16'h0000);
    chk("t1_word0", rd_data[0], 32'h0000_0013);
    rd_ram_addr = 16'h0004;
    #1 chk("t1_latency", rd_data[0], 32'h0000_0013);
    tick();
    chk("t1_word1", rd_data[0], 32'h0000_50B7);
    chk("t1_word1_small", rd_data[1], 32'h0000_50B7);

    // Partial word, and done coinciding with the 4th byte.
    pulse_reload();
    chk("t3_reload_loaded", 32'(loaded_o[0]), 32'd0);
    send(8'hAA); send(8'hBB); pulse_done();
    chk("t3_partial_loaded", 32'(loaded_o[0]), 32'd1);
    rd(16'h0000);
    chk("t3_partial_word", rd_data[0], 32'h0000_BBAA);
    pulse_reload();
    send(8'hAA); send(8'hBB); send(8'hCC); send_done(8'hDD);
    chk("t3_full_loaded", 32'(loaded_o[0]), 32'd1);
    rd(16'h0000);
    chk("t3_full_word", rd_data[0], 32'hDDCC_BBAA);
    rd(16'h0004);
    chk("t3_word1_retained", rd_data[0], 32'h0000_50B7);

    // 16 bytes with a 5-cycle stall mid-word: small instance fills and auto-serves.
    pulse_reload();
    for (int i = 0; i < 16; i++) begin
      send(8'(8'h10 + i));
      if (i == 5) repeat (5) tick();
    end
    chk("t4_small_serving", 32'(serving_o[1]), 32'd1);
    chk("t4_small_ready", 32'(ready_o[1]), 32'd0);
    chk("t4_small_loaded", 32'(loaded_o[1]), 32'd4);
    chk("t4_big_serving", 32'(serving_o[0]), 32'd0);
    send(8'hEE);
    pulse_done();
    chk("t4_small_extra_ignored", 32'(loaded_o[1]), 32'd4);
    chk("t4_big_loaded", 32'(loaded_o[0]), 32'd5);
    rd(16'h0010);
    chk("t4_small_oor", rd_data[1], NOP);
    chk("t4_big_word4", rd_data[0], 32'h0000_00EE);
    rd(16'h1000);
    chk("t4_big_oor", rd_data[0], NOP);
    rd(16'h000C);
    chk("t4_small_word3", rd_data[1], 32'h1F1E_1D1C);
    rd(16'h0003);
    chk("t4_small_word0", rd_data[1], 32'h1312_1110);
    chk("t5_stall_word", rd_data[0], 32'h1312_1110);

    // Reload drops back to LOAD; reads return NOP.
    pulse_reload();
    chk("t5_reload_serving", 32'(serving_o[0]), 32'd0);
    rd(16'h0003);
    chk("t5_reload_nop", rd_data[0], NOP);

    // Reset mid-word, then a fresh 1-byte load must not carry stale lanes.
    send(8'h11); send(8'h22);
    reset = 1'b1;
    #1 chk("t6_reset_rd", rd_data[0], NOP);
    tick(); tick();
    reset = 1'b0;
    send(8'h33);
    pulse_done();
    chk("t6_loaded", 32'(loaded_o[0]), 32'd1);
    rd(16'h0000);
    chk("t6_no_stale", rd_data[0], 32'h0000_0033);
    reset = 1'b1;
    #1 chk("t6_async_rd", rd_data[0], NOP);
    chk("t6_async_serving", 32'(serving_o[0]), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
